// File: rtl/ntt_pkg.sv
// Shared NTT definitions: sequencer states, derived address/index widths and
// default latencies used by the array, memory wrappers and their controller.
package ntt_pkg;

   localparam int unsigned DEPTH_DEF    = 16;
   localparam int unsigned LUT_SIZE_DEF = 1360;
   localparam int unsigned RD_LAT_DEF   = 1;
   localparam int unsigned PIPE_LAT_DEF = 4;

   localparam int unsigned ADDR_W = $clog2(DEPTH_DEF);
   localparam int unsigned WIDX_W = $clog2(LUT_SIZE_DEF);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } ctrl_state_e;

endpackage

// File: rtl/delay_line.sv
// Fixed-length shift register; reset clears every stage so nothing stale
// emerges after a mid-stream reset.
module delay_line #(
   parameter int unsigned W = 1,
   parameter int unsigned N = 1
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout
);

   logic [W-1:0] stage_q [N];
   logic [W-1:0] stage_d [N];

   always_comb begin
      stage_d[0] = din;
      for (int i = 1; i < int'(N); i++) begin
         stage_d[i] = stage_q[i-1];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         stage_q <= '{default: '0};
      end else begin
         stage_q <= stage_d;
      end
   end

   assign dout = stage_q[N-1];

endmodule

// File: rtl/butterfly_array_ctrl.sv
// Pass/row sequencer for the butterfly array: reads each row, steers twiddle
// index and mode controls, and writes the result back L cycles later.
module butterfly_array_ctrl
   import ntt_pkg::*;
#(
   parameter int unsigned WIDTH    = 32,
   parameter int unsigned SIZE     = 128,
   parameter int unsigned LUT_SIZE = LUT_SIZE_DEF,
   parameter int unsigned DEPTH    = DEPTH_DEF,
   parameter int unsigned RD_LAT   = RD_LAT_DEF,
   parameter int unsigned PIPE_LAT = PIPE_LAT_DEF
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        start,
   input  logic [7:0]                  n_passes,
   input  logic [$clog2(DEPTH):0]      n_rows,
   input  logic [$clog2(LUT_SIZE)-1:0] w_base,
   input  logic [$clog2(LUT_SIZE)-1:0] w_step,
   input  logic                        mode_i,
   input  logic                        swap_i,
   output logic                        busy,
   output logic                        done,
   output logic                        rd_en,
   output logic [$clog2(DEPTH)-1:0]    rd_addr,
   output logic                        wr_en,
   output logic [$clog2(DEPTH)-1:0]    wr_addr,
   output logic                        bf_mode,
   output logic                        bf_swap,
   output logic [$clog2(LUT_SIZE)-1:0] bf_w_idx
);

   localparam int unsigned AW  = $clog2(DEPTH);
   localparam int unsigned WW  = $clog2(LUT_SIZE);
   localparam int unsigned SW  = WW + 1;
   localparam int unsigned CW  = AW + 1;
   localparam int unsigned LAT = RD_LAT + PIPE_LAT;
   localparam int unsigned DW  = $clog2(LAT) + 1;

   if (RD_LAT < 1 || PIPE_LAT < 1 || WIDTH < 1 || SIZE < 1) begin : g_bad_cfg
      $error("butterfly_array_ctrl: latencies, WIDTH and SIZE must be >= 1");
   end

   ctrl_state_e   state_q, state_d;
   logic [7:0]    pass_q, pass_d;
   logic [7:0]    n_passes_q, n_passes_d;
   logic [CW-1:0] n_rows_q, n_rows_d;
   logic [WW-1:0] w_step_q, w_step_d;
   logic [AW-1:0] row_q, row_d;
   logic [WW-1:0] acc_q, acc_d;
   logic [DW-1:0] drain_q, drain_d;
   logic          mode_q, mode_d;
   logic          swap_q, swap_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          rd_en_q, rd_en_d;
   logic [WW-1:0] w_idx_q, w_idx_d;

   logic [SW-1:0] acc_sum;
   logic [WW-1:0] acc_nxt;
   logic          last_row;
   logic [7:0]    pass_inc;
   logic [AW:0]   wr_bus;
   logic [WW:0]   tw_bus;

   // Modular twiddle step and end-of-pass detection
   always_comb begin
      acc_sum  = {1'b0, acc_q} + {1'b0, w_step_q};
      acc_nxt  = (acc_sum >= SW'(LUT_SIZE)) ? WW'(acc_sum - SW'(LUT_SIZE)) : acc_sum[WW-1:0];
      last_row = ({1'b0, row_q} == (n_rows_q - CW'(1)));
      pass_inc = pass_q + 8'd1;
   end

   always_comb begin
      state_d    = state_q;
      pass_d     = pass_q;
      n_passes_d = n_passes_q;
      n_rows_d   = n_rows_q;
      w_step_d   = w_step_q;
      row_d      = row_q;
      acc_d      = acc_q;
      drain_d    = drain_q;
      mode_d     = mode_q;
      swap_d     = swap_q;

      unique case (state_q)
         IDLE: begin
            if (start) begin
               n_passes_d = n_passes;
               n_rows_d   = n_rows;
               w_step_d   = w_step;
               mode_d     = mode_i;
               swap_d     = swap_i;
               pass_d     = '0;
               row_d      = '0;
               acc_d      = w_base;
               state_d    = (n_passes == 8'd0 || n_rows == '0) ? DONE : ISSUE;
            end
         end
         ISSUE: begin
            acc_d = acc_nxt;
            if (last_row) begin
               drain_d = '0;
               state_d = DRAIN;
            end else begin
               row_d = row_q + AW'(1);
            end
         end
         DRAIN: begin
            drain_d = drain_q + DW'(1);
            // Wait for the last write of the pass to retire before re-reading
            if (drain_q == DW'(LAT - 1)) begin
               pass_d = pass_inc;
               if (pass_inc == n_passes_q) begin
                  state_d = DONE;
               end else begin
                  row_d   = '0;
                  state_d = ISSUE;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d  = (state_d == ISSUE) || (state_d == DRAIN);
      done_d  = (state_d == DONE);
      rd_en_d = (state_d == ISSUE);
      w_idx_d = tw_bus[WW] ? tw_bus[WW-1:0] : w_idx_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         pass_q     <= '0;
         n_passes_q <= '0;
         n_rows_q   <= '0;
         w_step_q   <= '0;
         row_q      <= '0;
         acc_q      <= '0;
         drain_q    <= '0;
         mode_q     <= 1'b0;
         swap_q     <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         rd_en_q    <= 1'b0;
         w_idx_q    <= '0;
      end else begin
         state_q    <= state_d;
         pass_q     <= pass_d;
         n_passes_q <= n_passes_d;
         n_rows_q   <= n_rows_d;
         w_step_q   <= w_step_d;
         row_q      <= row_d;
         acc_q      <= acc_d;
         drain_q    <= drain_d;
         mode_q     <= mode_d;
         swap_q     <= swap_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         rd_en_q    <= rd_en_d;
         w_idx_q    <= w_idx_d;
      end
   end

   // Read command replayed as the write-back L cycles later
   delay_line #(.W(AW + 1), .N(LAT)) u_wr_dly (
      .clk  (clk),
      .reset(reset),
      .din  ({rd_en_q, row_q}),
      .dout (wr_bus)
   );

   // Fed one cycle ahead of the read so the hold register lands at read + RD_LAT
   delay_line #(.W(WW + 1), .N(RD_LAT)) u_tw_dly (
      .clk  (clk),
      .reset(reset),
      .din  ({rd_en_d, acc_d}),
      .dout (tw_bus)
   );

   assign busy     = busy_q;
   assign done     = done_q;
   assign rd_en    = rd_en_q;
   assign rd_addr  = row_q;
   assign wr_en    = wr_bus[AW];
   assign wr_addr  = wr_bus[AW-1:0];
   assign bf_mode  = mode_q;
   assign bf_swap  = swap_q;
   assign bf_w_idx = w_idx_q;

endmodule

// File: tb/tb_butterfly_array_ctrl.sv
// Scoreboard bench: job model predicts timed events, a negedge monitor pops
// and compares them against what the sequencer presents.
module tb_butterfly_array_ctrl;
   import ntt_pkg::*;

   localparam int RD_LAT   = 1;
   localparam int PIPE_LAT = 4;
   localparam int L        = RD_LAT + PIPE_LAT;
   localparam int LUT      = 1360;
   localparam int DEPTH    = 16;

   logic                clk;
   logic                reset;
   logic                start;
   logic [7:0]          n_passes;
   logic [ADDR_W:0]     n_rows;
   logic [WIDX_W-1:0]   w_base;
   logic [WIDX_W-1:0]   w_step;
   logic                mode_i;
   logic                swap_i;
   logic                busy;
   logic                done;
   logic                rd_en;
   logic [ADDR_W-1:0]   rd_addr;
   logic                wr_en;
   logic [ADDR_W-1:0]   wr_addr;
   logic                bf_mode;
   logic                bf_swap;
   logic [WIDX_W-1:0]   bf_w_idx;

   butterfly_array_ctrl #(
      .WIDTH(32), .SIZE(128), .LUT_SIZE(LUT), .DEPTH(DEPTH),
      .RD_LAT(RD_LAT), .PIPE_LAT(PIPE_LAT)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .n_passes(n_passes),
      .n_rows(n_rows), .w_base(w_base), .w_step(w_step), .mode_i(mode_i),
      .swap_i(swap_i), .busy(busy), .done(done), .rd_en(rd_en),
      .rd_addr(rd_addr), .wr_en(wr_en), .wr_addr(wr_addr), .bf_mode(bf_mode),
      .bf_swap(bf_swap), .bf_w_idx(bf_w_idx)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int cyc;
      int a;
      int b;
   } ev_t;
   typedef ev_t evq_t[$];

   evq_t rd_q, wr_q, idx_q, mode_q, busy_q, done_q;
   int   zero_q[$];
   int   cyc = 0;
   int   total = 0;
   int   bad = 0;
   int   cur_idx = 0, cur_mode = 0, cur_swap = 0, cur_busy = 0;
   bit   mon_en = 1'b0;
   ev_t  e_m;
   int   z_m;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic ev_t mk(input int c, input int a, input int b);
      ev_t e;
      e.cyc = c;
      e.a   = a;
      e.b   = b;
      return e;
   endfunction

   function automatic evq_t keep_upto(input evq_t q, input int rc);
      evq_t r;
      foreach (q[i]) if (q[i].cyc <= rc) r.push_back(q[i]);
      return r;
   endfunction

   // Reference model: every read, write, index, level change and done of a job
   task automatic expect_job(input int s, input int p_n, input int r_n, input int base,
                             input int step, input int m, input int sw);
      int rc;
      mode_q.push_back(mk(s + 1, m, sw));
      if (p_n == 0 || r_n == 0) begin
         done_q.push_back(mk(s + 1, 0, 0));
      end else begin
         busy_q.push_back(mk(s + 1, 1, 0));
         for (int p = 0; p < p_n; p++) begin
            for (int r = 0; r < r_n; r++) begin
               rc = s + 1 + p * (r_n + L) + r;
               rd_q.push_back(mk(rc, r, 0));
               wr_q.push_back(mk(rc + L, r, 0));
               idx_q.push_back(mk(rc + RD_LAT, (base + (p * r_n + r) * step) % LUT, 0));
            end
         end
         busy_q.push_back(mk(s + p_n * (r_n + L) + 1, 0, 0));
         done_q.push_back(mk(s + p_n * (r_n + L) + 1, 0, 0));
      end
   endtask

   task automatic flush_after(input int rc);
      rd_q   = keep_upto(rd_q, rc);
      wr_q   = keep_upto(wr_q, rc);
      idx_q  = keep_upto(idx_q, rc);
      mode_q = keep_upto(mode_q, rc);
      busy_q = keep_upto(busy_q, rc);
      done_q = keep_upto(done_q, rc);
      zero_q.push_back(rc + 1);
      idx_q.push_back(mk(rc + 1, 0, 0));
      mode_q.push_back(mk(rc + 1, 0, 0));
      busy_q.push_back(mk(rc + 1, 0, 0));
   endtask

   // Monitor
   always @(negedge clk) begin
      if (mon_en) begin
         if (rd_en) begin
            if (rd_q.size() == 0) chk("rd_unexpected", cyc, -1);
            else begin
               e_m = rd_q.pop_front();
               chk("rd_cycle", cyc, e_m.cyc);
               chk("rd_addr", int'(rd_addr), e_m.a);
            end
         end else if (rd_q.size() != 0 && rd_q[0].cyc <= cyc) begin
            e_m = rd_q.pop_front();
            chk("rd_missing", -1, e_m.cyc);
         end

         if (wr_en) begin
            if (wr_q.size() == 0) chk("wr_unexpected", cyc, -1);
            else begin
               e_m = wr_q.pop_front();
               chk("wr_cycle", cyc, e_m.cyc);
               chk("wr_addr", int'(wr_addr), e_m.a);
            end
         end else if (wr_q.size() != 0 && wr_q[0].cyc <= cyc) begin
            e_m = wr_q.pop_front();
            chk("wr_missing", -1, e_m.cyc);
         end

         if (done) begin
            if (done_q.size() == 0) chk("done_unexpected", cyc, -1);
            else begin
               e_m = done_q.pop_front();
               chk("done_cycle", cyc, e_m.cyc);
            end
         end else if (done_q.size() != 0 && done_q[0].cyc <= cyc) begin
            e_m = done_q.pop_front();
            chk("done_missing", -1, e_m.cyc);
         end

         while (idx_q.size() != 0 && idx_q[0].cyc <= cyc) begin
            e_m = idx_q.pop_front();
            cur_idx = e_m.a;
         end
         chk("w_idx", int'(bf_w_idx), cur_idx);

         while (mode_q.size() != 0 && mode_q[0].cyc <= cyc) begin
            e_m = mode_q.pop_front();
            cur_mode = e_m.a;
            cur_swap = e_m.b;
         end
         chk("bf_mode", int'(bf_mode), cur_mode);
         chk("bf_swap", int'(bf_swap), cur_swap);

         while (busy_q.size() != 0 && busy_q[0].cyc <= cyc) begin
            e_m = busy_q.pop_front();
            cur_busy = e_m.a;
         end
         chk("busy", int'(busy), cur_busy);

         if (zero_q.size() != 0 && zero_q[0] <= cyc) begin
            z_m = zero_q.pop_front();
            chk("reset_outputs_zero",
                int'({rd_en, rd_addr, wr_en, wr_addr, bf_mode, bf_swap, bf_w_idx, busy, done}), 0);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one job; optionally a spurious start at s+5 or a reset at s+rst_off
   task automatic run_job(input int p_n, input int r_n, input int base, input int step,
                          input int m, input int sw, input int spur, input int rst_off);
      int s, x, endc;
      s        = cyc;
      start    = 1'b1;
      n_passes = 8'(p_n);
      n_rows   = (ADDR_W + 1)'(r_n);
      w_base   = WIDX_W'(base);
      w_step   = WIDX_W'(step);
      mode_i   = m[0];
      swap_i   = sw[0];
      expect_job(s, p_n, r_n, base, step, m, sw);
      x = (p_n == 0 || r_n == 0) ? 0 : p_n * (r_n + L);
      tick();
      start = 1'b0;
      endc  = s + x + 2;
      while (cyc < endc) begin
         n_passes = 8'($urandom);
         n_rows   = (ADDR_W + 1)'($urandom);
         w_base   = WIDX_W'($urandom);
         w_step   = WIDX_W'($urandom);
         mode_i   = 1'($urandom);
         swap_i   = 1'($urandom);
         start    = (spur != 0 && rst_off == 0 && cyc == s + 5 && x >= 5);
         if (rst_off != 0 && cyc == s + rst_off) begin
            reset = 1'b1;
            flush_after(cyc);
            endc = cyc + 2;
         end else begin
            reset = 1'b0;
         end
         tick();
      end
      start = 1'b0;
      reset = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation bound reached at cycle %0d", cyc);
      $fatal(1, "timeout");
   end

   initial begin
      int p_n, r_n, x, kind;
      reset = 1'b1; start = 1'b0; n_passes = '0; n_rows = '0;
      w_base = '0; w_step = '0; mode_i = 1'b0; swap_i = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      reset  = 1'b0;
      zero_q.push_back(cyc);
      mon_en = 1'b1;
      tick();

      run_job(1, 4, 10, 3, 0, 0, 0, 0);        // basic job
      run_job(1, 4, 1358, 1, 1, 0, 0, 0);      // twiddle wrap
      run_job(2, 3, 0, 2, 0, 1, 0, 0);         // two passes, continuity
      run_job(1, 0, 5, 7, 1, 1, 0, 0);         // zero rows
      run_job(0, 4, 5, 7, 0, 0, 0, 0);         // zero passes
      run_job(1, 4, 10, 3, 1, 1, 0, 3);        // mid-job reset
      run_job(1, 4, 10, 3, 0, 0, 0, 0);        // accepted after reset
      run_job(1, 4, 10, 3, 1, 1, 1, 0);        // start while busy ignored
      run_job(3, 16, 1300, 1359, 1, 0, 0, 0);  // full depth, large step

      for (int j = 0; j < 30; j++) begin
         p_n  = $urandom_range(0, 3);
         r_n  = $urandom_range(0, DEPTH);
         x    = (p_n == 0 || r_n == 0) ? 0 : p_n * (r_n + L);
         kind = $urandom_range(0, 3);
         run_job(p_n, r_n, $urandom_range(0, LUT - 1), $urandom_range(0, LUT - 1),
                 $urandom_range(0, 1), $urandom_range(0, 1), (kind == 1) ? 1 : 0,
                 (kind == 0 && x > 0) ? $urandom_range(1, x) : 0);
         repeat ($urandom_range(0, 2)) tick();
      end

      repeat (4) tick();
      chk("leftover_rd", rd_q.size(), 0);
      chk("leftover_wr", wr_q.size(), 0);
      chk("leftover_done", done_q.size(), 0);
      chk("leftover_idx", idx_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
